calc2_port_issuer: RTL

CALC2_PORT_ISSUER -- requirements
Module: calc2_port_issuer

---
 rtl/calc2_pkg.sv | 34 +++
 rtl/calc2_rsp_fifo.sv | 49 ++++
 rtl/calc2_port_issuer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/calc2_pkg.sv
// Shared widths, command/response codes and the response record for the calc2 port issuer.
package calc2_pkg;
    localparam int CMD_W    = 4;
    localparam int TAG_W    = 2;
    localparam int DATA_W   = 32;
    localparam int RESP_W   = 2;
    localparam int NUM_TAGS = 4;

    localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
    localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
    localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
    localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
    localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

    typedef enum logic [RESP_W-1:0] {
        RESP_NONE = 2'd0,
        RESP_OK   = 2'd1,
        RESP_OVF  = 2'd2,
        RESP_INV  = 2'd3
    } resp_e;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [RESP_W-1:0] code;
        logic [DATA_W-1:0] data;
    } rsp_entry_t;

    function automatic logic [TAG_W-1:0] lowest_free(input logic [NUM_TAGS-1:0] alloc);
        lowest_free = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!alloc[i]) lowest_free = TAG_W'(i);
        end
    endfunction
endpackage

// File: rtl/calc2_rsp_fifo.sv
// Small synchronous FIFO holding completed calculator responses; head reads as zero when empty.
module calc2_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && ((count != FULL) || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/calc2_port_issuer.sv
// Issues two-beat commands to a 4-tag calculator port and queues tagged responses in order of arrival.
// Tags are freed only when their response is popped downstream.
module calc2_port_issuer
    import calc2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CMD_W-1:0]  req_cmd,
    input  logic [DATA_W-1:0] req_op1,
    input  logic [DATA_W-1:0] req_op2,
    output logic [CMD_W-1:0]  req_cmd_in,
    output logic [TAG_W-1:0]  req_tag_in,
    output logic [DATA_W-1:0] req_data_in,
    input  logic [RESP_W-1:0] resp_out,
    input  logic [TAG_W-1:0]  tag_out,
    input  logic [DATA_W-1:0] data_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [RESP_W-1:0] rsp_code,
    output logic [DATA_W-1:0] rsp_data,
    output logic [2:0]        outstanding,
    output logic              err_spurious,
    output logic              err_timeout
);
    // state | meaning
    // IDLE  | may accept a request; issue beat carries cmd, tag and op1
    // OP2   | second beat carries latched op2; no acceptance
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] OP2  = 1'b1;

    logic [0:0]          state;
    logic [NUM_TAGS-1:0] alloc;
    logic [NUM_TAGS-1:0] responded;
    logic [7:0]          age [NUM_TAGS];
    logic [TAG_W-1:0]    tag_q;
    logic [DATA_W-1:0]   op2_q;
    logic [TAG_W-1:0]    free_tag;
    logic                issue;
    logic                rsp_hit;
    logic                rsp_good;
    logic                pop;
    logic                fifo_empty;
    logic                timeout_hit;
    rsp_entry_t          push_entry;
    rsp_entry_t          head_entry;

    assign free_tag  = lowest_free(alloc);
    // Gated by reset so the handshake reads zero while reset is held.
    assign req_ready = reset && (state == IDLE) && req_valid && ((req_cmd == CMD_NOP) || !(&alloc));
    assign issue     = req_ready && (req_cmd != CMD_NOP);

    always_comb begin
        req_cmd_in  = '0;
        req_tag_in  = '0;
        req_data_in = '0;
        if (issue) begin
            req_cmd_in  = req_cmd;
            req_tag_in  = free_tag;
            req_data_in = req_op1;
        end else if (state == OP2) begin
            req_tag_in  = tag_q;
            req_data_in = op2_q;
        end
    end

    assign rsp_hit    = (resp_out != RESP_NONE);
    assign rsp_good   = rsp_hit && alloc[tag_out] && !responded[tag_out];
    assign push_entry = '{tag: tag_out, code: resp_out, data: data_out};
    assign pop        = rsp_valid && rsp_ready;

    calc2_rsp_fifo #(
        .DEPTH (NUM_TAGS),
        .WIDTH ($bits(rsp_entry_t))
    ) u_rsp_fifo (
        .clk       (c_clk),
        .rst_n     (reset),
        .push      (rsp_good),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_entry),
        .empty     (fifo_empty)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_tag   = head_entry.tag;
    assign rsp_code  = head_entry.code;
    assign rsp_data  = head_entry.data;

    always_comb begin
        outstanding = '0;
        timeout_hit = 1'b0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            outstanding = outstanding + {2'b00, alloc[i]};
            if (alloc[i] && !responded[i] && (int'(age[i]) + 1 >= TIMEOUT_CYCLES)) timeout_hit = 1'b1;
        end
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            alloc        <= '0;
            responded    <= '0;
            tag_q        <= '0;
            op2_q        <= '0;
            err_spurious <= 1'b0;
            err_timeout  <= 1'b0;
            for (int i = 0; i < NUM_TAGS; i++) age[i] <= '0;
        end else begin
            state <= issue ? OP2 : IDLE;
            if (issue) begin
                tag_q <= free_tag;
                op2_q <= req_op2;
            end
            if (rsp_hit && !rsp_good) err_spurious <= 1'b1;
            if (timeout_hit) err_timeout <= 1'b1;
            // The issuing tag was free, the popped tag is responded and a good response is unresponded,
            // so at most one of these events can touch a given tag per cycle.
            for (int i = 0; i < NUM_TAGS; i++) begin
                if (issue && (free_tag == TAG_W'(i))) begin
                    alloc[i]     <= 1'b1;
                    responded[i] <= 1'b0;
                    age[i]       <= '0;
                end else begin
                    if (pop && (head_entry.tag == TAG_W'(i))) begin
                        alloc[i]     <= 1'b0;
                        responded[i] <= 1'b0;
                    end else if (rsp_good && (tag_out == TAG_W'(i))) begin
                        responded[i] <= 1'b1;
                    end
                    if (alloc[i] && !responded[i] && (age[i] != 8'hFF)) age[i] <= age[i] + 8'd1;
                end
            end
        end
    end
endmodule
